// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with a configurable word width,
// optional odd/even parity and one or two stop bits. A received word stays in
// data with rdy high until the host acknowledges it. Framing, parity and
// overrun errors are reported alongside the word.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | line idle, waiting for rx_s to go low
// START     | half a bit into the start bit, confirm it is still low
// DATA      | sample one data bit per bit period, LSB first
// PAR       | sample the parity bit and evaluate it
// STOP      | sample the stop bit(s), commit after the last one
// WAIT_HIGH | line held low after the frame, wait for it to go idle
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

  state_t               state;
  logic                 rx_m;
  logic                 rx_s;
  logic [BW-1:0]        baud_cnt;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_acc;
  logic                 perr_acc;
  logic                 commit;

  // Two-flop synchroniser for the asynchronous serial line (idle high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Frame sequencing plus the host-facing holding register and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      ferr_acc   <= 1'b0;
      perr_acc   <= 1'b0;
      commit     <= 1'b0;
      data       <= '0;
      rdy        <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      commit <= 1'b0;

      // The ack is applied first so a same-cycle commit can reload the word.
      if (rd_ack && rdy) begin
        rdy        <= 1'b0;
        overrun    <= 1'b0;
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
      end
      if (commit) begin
        if (!rdy || rd_ack) begin
          data       <= shreg;
          frame_err  <= ferr_acc;
          parity_err <= perr_acc;
          rdy        <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            ferr_acc <= 1'b0;
            perr_acc <= 1'b0;
          end
        end
        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PAR: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            // Odd parity expects an overall XOR of 1, even parity of 0.
            perr_acc <= (PARITY == 1) ? ~(^{shreg, rx_s}) : (^{shreg, rx_s});
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (!rx_s) ferr_acc <= 1'b1;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              commit  <= 1'b1;
              state   <= rx_s ? IDLE : WAIT_HIGH;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: one 8N1 instance with default parameters and
// one 7-bit, even-parity, two-stop-bit instance, driven with directed and
// random frames and compared against a frame-level reference model.
module tb_uart_rx_param;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       ack_a = 1'b0, ack_b = 1'b0;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       rdy_a, fe_a, pe_a, ov_a;
  logic       rdy_b, fe_b, pe_b, ov_b;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t_start[2];
  int rise_a = 0, rise_b = 0;
  logic rdy_a_q = 1'b0, rdy_b_q = 1'b0;

  uart_rx_param u_a (
    .clk(clk), .rst(rst), .rx(rx_a), .rd_ack(ack_a),
    .data(data_a), .rdy(rdy_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .rst(rst), .rx(rx_b), .rd_ack(ack_b),
    .data(data_b), .rdy(rdy_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle on which rdy rises, for the latency checks.
  always @(negedge clk) begin
    if (rdy_a && !rdy_a_q) rise_a = cyc;
    if (rdy_b && !rdy_b_q) rise_b = cyc;
    rdy_a_q = rdy_a;
    rdy_b_q = rdy_b;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: expected results computed from the frame as sent.
  function automatic logic model_perr(input logic [8:0] w, input int nbits, input logic pbit);
    int ones = 0;
    for (int i = 0; i < nbits; i++) ones += w[i];
    return ((ones + pbit) % 2) != 0;   // even parity: odd total count is an error
  endfunction

  function automatic int model_latency(input int nbits, input int p, input int nstop);
    return 2 + CPB / 2 + (nbits + p + nstop) * CPB + 1;
  endfunction

  task automatic set_rx(input int inst, input logic v);
    if (inst == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic hold_bit(input int inst, input logic v);
    set_rx(inst, v);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send(input int inst, input logic [8:0] w, input int nbits, input bit has_par,
                      input logic pbit, input int nstop, input logic s1, input logic s2);
    t_start[inst] = cyc;
    hold_bit(inst, 1'b0);
    for (int i = 0; i < nbits; i++) hold_bit(inst, w[i]);
    if (has_par) hold_bit(inst, pbit);
    hold_bit(inst, s1);
    if (nstop == 2) hold_bit(inst, s2);
    set_rx(inst, 1'b1);
  endtask

  task automatic send_a(input logic [7:0] w, input logic s1);
    send(0, {1'b0, w}, 8, 1'b0, 1'b0, 1, s1, 1'b1);
  endtask

  task automatic send_b(input logic [6:0] w, input logic pbit, input logic s1, input logic s2);
    send(1, {2'b00, w}, 7, 1'b1, pbit, 2, s1, s2);
  endtask

  task automatic wait_rdy(input int inst, input int budget);
    int n = 0;
    while (((inst == 0) ? rdy_a : rdy_b) == 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (((inst == 0) ? rdy_a : rdy_b) == 1'b0) check_val("rdy_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_word(input int inst, input string tag, input logic [8:0] d,
                            input logic fe, input logic pe, input logic ov, input logic r);
    if (inst == 0) begin
      check_val({tag, "_data"}, {24'd0, data_a}, {23'd0, d});
      check_val({tag, "_rdy"}, {31'd0, rdy_a}, {31'd0, r});
      check_val({tag, "_ferr"}, {31'd0, fe_a}, {31'd0, fe});
      check_val({tag, "_perr"}, {31'd0, pe_a}, {31'd0, pe});
      check_val({tag, "_ovr"}, {31'd0, ov_a}, {31'd0, ov});
    end else begin
      check_val({tag, "_data"}, {25'd0, data_b}, {23'd0, d});
      check_val({tag, "_rdy"}, {31'd0, rdy_b}, {31'd0, r});
      check_val({tag, "_ferr"}, {31'd0, fe_b}, {31'd0, fe});
      check_val({tag, "_perr"}, {31'd0, pe_b}, {31'd0, pe});
      check_val({tag, "_ovr"}, {31'd0, ov_b}, {31'd0, ov});
    end
  endtask

  // One-cycle ack pulse; rdy, overrun and the error flags must drop next cycle.
  task automatic do_ack(input int inst, input string tag);
    if (inst == 0) ack_a = 1'b1;
    else ack_b = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
    ack_b = 1'b0;
    if (inst == 0) begin
      check_val({tag, "_ack_rdy"}, {31'd0, rdy_a}, 32'd0);
      check_val({tag, "_ack_ovr"}, {31'd0, ov_a}, 32'd0);
      check_val({tag, "_ack_ferr"}, {31'd0, fe_a}, 32'd0);
    end else begin
      check_val({tag, "_ack_rdy"}, {31'd0, rdy_b}, 32'd0);
      check_val({tag, "_ack_ovr"}, {31'd0, ov_b}, 32'd0);
      check_val({tag, "_ack_perr"}, {31'd0, pe_b}, 32'd0);
    end
  endtask

  initial begin
    int lat;
    logic [7:0] wa;
    logic [6:0] wb;
    logic s1, s2, pb;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_word(0, "reset_a", 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    check_word(1, "reset_b", 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);

    // 8N1 word with latency measurement.
    send_a(8'hA5, 1'b1);
    wait_rdy(0, 4 * CPB);
    check_word(0, "a5", 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b1);
    lat = rise_a - t_start[0] - 1;
    check_val("lat_a_in_window", {31'd0, (lat >= model_latency(8, 0, 1) - 1) && (lat <= model_latency(8, 0, 1) + 1)}, 32'd1);
    do_ack(0, "a5");

    // Short low glitch on an idle line: no frame.
    rx_a = 1'b0;
    repeat (5) @(negedge clk);
    rx_a = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_word(0, "glitch", 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0);

    // Even parity, 7 data bits, 2 stop bits.
    send_b(7'h41, model_perr(9'h041, 7, 1'b0) ? 1'b1 : 1'b0, 1'b1, 1'b1);
    wait_rdy(1, 4 * CPB);
    check_word(1, "b41", 9'h041, 1'b0, 1'b0, 1'b0, 1'b1);
    lat = rise_b - t_start[1] - 1;
    check_val("lat_b_in_window", {31'd0, (lat >= model_latency(7, 1, 2) - 1) && (lat <= model_latency(7, 1, 2) + 1)}, 32'd1);
    do_ack(1, "b41");
    send_b(7'h41, 1'b1, 1'b1, 1'b1);
    wait_rdy(1, 4 * CPB);
    check_word(1, "b41_badpar", 9'h041, 1'b0, model_perr(9'h041, 7, 1'b1), 1'b0, 1'b1);
    do_ack(1, "b41_badpar");

    // Second stop bit low, then line held low for 40 bit times.
    send_b(7'h3C, 1'b0, 1'b1, 1'b0);
    rx_b = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    rx_b = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_word(1, "b3c_break", 9'h03C, 1'b1, 1'b0, 1'b0, 1'b1);
    do_ack(1, "b3c_break");
    send_b(7'h55, 1'b0, 1'b1, 1'b1);
    wait_rdy(1, 4 * CPB);
    check_word(1, "b55", 9'h055, 1'b0, 1'b0, 1'b0, 1'b1);
    do_ack(1, "b55");

    // Back-to-back frames without an ack: second frame lost, overrun set.
    send_a(8'h11, 1'b1);
    send_a(8'h22, 1'b1);
    repeat (CPB) @(negedge clk);
    check_word(0, "overrun", 9'h011, 1'b0, 1'b0, 1'b1, 1'b1);
    do_ack(0, "overrun");

    // Reset in the middle of the data bits of 0xFF.
    rx_a = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_a = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    check_word(0, "mid_reset", 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    send_a(8'h0F, 1'b1);
    wait_rdy(0, 4 * CPB);
    check_word(0, "after_reset", 9'h00F, 1'b0, 1'b0, 1'b0, 1'b1);
    do_ack(0, "after_reset");

    // Random frames on the 8N1 instance, occasionally with a bad stop bit.
    for (int k = 0; k < 12; k++) begin
      wa = 8'($urandom_range(0, 255));
      s1 = ($urandom_range(0, 3) != 0);
      send_a(wa, s1);
      wait_rdy(0, 4 * CPB);
      check_word(0, "rand_a", {1'b0, wa}, ~s1, 1'b0, 1'b0, 1'b1);
      do_ack(0, "rand_a");
      repeat (2 * CPB) @(negedge clk);
    end

    // Random frames on the parity instance with random parity/stop faults.
    for (int k = 0; k < 12; k++) begin
      wb = 7'($urandom_range(0, 127));
      pb = 1'($urandom_range(0, 1));
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
      send_b(wb, pb, s1, s2);
      wait_rdy(1, 4 * CPB);
      check_word(1, "rand_b", {2'b00, wb}, ~(s1 & s2), model_perr({2'b00, wb}, 7, pb), 1'b0, 1'b1);
      do_ack(1, "rand_b");
      repeat (2 * CPB) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver; successor to the single-rate 8-bit receiver. Oversamples the asynchronous serial line with a per-bit clock divider and validates the start bit at mid-bit. Supports configurable data width, optional parity, and 1 or 2 stop bits. Holds each received word for a host-side read handshake and reports framing, parity and overrun errors. Sits between the board RX pin and the bring-up command/loader logic.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; minimum 4; mid-bit point = CLKS_PER_BIT/2 (integer division).
DATA_BITS, 8, data bits per frame; range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx  in  1  serial input, asynchronous to clk, idle high
rd_ack  in  1  host consumed data; sampled on clk
data  out  DATA_BITS  received word, LSB = first bit on the line
rdy  out  1  data holds an unread word
frame_err  out  1  stop-bit error on the word in data
parity_err  out  1  parity error on the word in data
overrun  out  1  sticky: a frame was lost because rdy was still high

Behaviour:
- Reset (async assert, deasserted synchronously in effect): state IDLE; counters 0; data=0; rdy, frame_err, parity_err, overrun = 0; synchroniser flops = 1.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s; this adds 2 cycles of latency.
- States: IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
- IDLE: when rx_s==0, go to START and clear the bit counter.
- START: after CLKS_PER_BIT/2 cycles, sample rx_s.
  - If 0: go to DATA; the baud counter restarts.
  - If 1: glitch; return to IDLE with no output change.
- DATA: sample every CLKS_PER_BIT cycles from the start mid-point. Shift right into the shift register (LSB first). After DATA_BITS samples, go to PAR if PARITY!=0, otherwise to STOP.
- PAR: sample one bit and compute the error.
  - Odd parity: error if XOR(data bits, parity bit)==0.
  - Even parity: error if that XOR==1.
- STOP: sample STOP_BITS bits; any stop sample of 0 sets the frame error.
  - At the last stop mid-point: commit (see below).
  - Then go to IDLE if rx_s==1, else to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1 (break / stuck-low line), then go to IDLE. No new start is detected while in this state.
- Commit, on the cycle after the last stop sample:
  - If rdy==0: data <= shift register; frame_err and parity_err updated; rdy <= 1.
  - If rdy==1: the new word is discarded; data, error flags and rdy are unchanged; overrun <= 1.
- rd_ack while rdy==1: next cycle rdy=0 and overrun=0; frame_err and parity_err are cleared.
- rd_ack while rdy==0: ignored.
- rd_ack on the same cycle as a commit: the ack clears the old word first; the new word then commits (rdy stays 1) with no overrun.
- Latency: from the rx falling edge, rdy rises at 2 + CLKS_PER_BIT/2 + (DATA_BITS + P + STOP_BITS)·CLKS_PER_BIT + 1 cycles (±1), where P = 1 if PARITY!=0, else 0.
- Back-to-back frames: a new start bit is accepted as soon as the state returns to IDLE, i.e. half a bit before the nominal end of the stop bit.
- Reset mid-frame: the frame is abandoned immediately; there is no partial commit.
- Counter widths: $clog2(CLKS_PER_BIT) for the baud counter and $clog2(DATA_BITS+1) for the bit counter. No wrap occurs within legal parameter values.

Test Plan:
- Defaults: send 0xA5 (8N1, 16 clk/bit), then rd_ack -> data=0xA5, rdy=1 with no errors; rdy falls 1 cycle after rd_ack.
- Send a 0-level pulse of 5 cycles on an idle line -> returns to IDLE; rdy stays 0; no error flags.
- PARITY=2, DATA_BITS=7: send 0x41 with parity bit 0 -> data=0x41, parity_err=0. Resend with parity bit 1 -> parity_err=1.
- STOP_BITS=2: send 0x3C with the second stop bit forced to 0 -> frame_err=1. Hold rx low for 40 bit times, then release -> no further commits; the next frame 0x55 is received cleanly after rd_ack.
- Send 0x11 then 0x22 back-to-back with no rd_ack -> data=0x11, overrun=1. After rd_ack, overrun=0 and rdy=0.
- Assert rst mid-way through the DATA bits of 0xFF, release, then send 0x0F -> data=0x0F, rdy=1; 0xFF is never presented.
